prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 26 ++
 rtl/prog_loader_csum.sv | 18 +
 rtl/prog_loader.sv | 132 +++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// The CSUM state only exists when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

  localparam int DEF_D = 12;
  localparam int DEF_W = 9;
  localparam int CNT_W = 12;

  // Bits that must be zero in the count-high and word-high bytes.
  localparam logic [7:0] CNT_HI_RSVD = 8'hF0;
  localparam logic [7:0] W_HI_RSVD   = 8'hFE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_W_LO,
    S_W_HI,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/prog_loader_csum.sv
// Running XOR of stream bytes, with a clear used when a new load starts.
module prog_loader_csum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] sum
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs, independent of block order.
  always_ff @(posedge clk) begin
    if (reset || clear) sum <= '0;
    else if (en)        sum <= sum ^ data;
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses count + 9-bit words into instruction
// memory. Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int D = DEF_D,
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         in_valid,
  input  logic [7:0]   in_byte,
  output logic         in_ready,
  output logic         wr_en,
  output logic [D-1:0] wr_addr,
  output logic [W-1:0] wr_data,
  output logic         cpu_hold,
  output logic         load_done,
  output logic         err
);

  state_t             state_q, state_d;
  logic [7:0]         cnt_lo_q;
  logic [7:0]         lo_q;
  logic [CNT_W-1:0]   rem_q;
  logic [D-1:0]       idx_q;
  logic               xfer;
  logic               start_ok;
  logic               hi_bad;
  logic               w_bad;
  logic [CNT_W-1:0]   count_w;

  assign xfer     = in_valid && in_ready;
  assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign hi_bad   = (in_byte & CNT_HI_RSVD) != 8'h00;
  assign w_bad    = (in_byte & W_HI_RSVD) != 8'h00;
  assign count_w  = {in_byte[3:0], cnt_lo_q};

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t TAIL = S_CSUM;
  logic [7:0] csum;

  prog_loader_csum u_csum (
    .clk   (clk),
    .reset (reset),
    .clear (start_ok),
    .en    (xfer && state_q != S_CSUM),
    .data  (in_byte),
    .sum   (csum)
  );
`else
  localparam state_t TAIL = S_DONE;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch forms.
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start) state_d = S_CNT_LO;
      S_CNT_LO: if (xfer) state_d = S_CNT_HI;
      S_CNT_HI: if (xfer) begin
        if (hi_bad)             state_d = S_ERR;
        else if (count_w == '0) state_d = TAIL;
        else                    state_d = S_W_LO;
      end
      S_W_LO: if (xfer) state_d = S_W_HI;
      S_W_HI: if (xfer) begin
        if (w_bad)                        state_d = S_ERR;
        else if (rem_q == CNT_W'(1))      state_d = TAIL;
        else                              state_d = S_W_LO;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CSUM: if (xfer) state_d = (in_byte == csum) ? S_DONE : S_ERR;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    cpu_hold  = 1'b0;
    load_done = 1'b0;
    err       = 1'b0;
    case (state_q)
      S_DONE: load_done = 1'b1;
      S_ERR:  err       = 1'b1;
      S_IDLE: ;
      default: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
      end
    endcase
  end

  // Word capture and the registered one-cycle write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_lo_q <= '0;
      lo_q     <= '0;
      rem_q    <= '0;
      idx_q    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_en <= 1'b0;
      if (start_ok) idx_q <= '0;
      if (xfer) begin
        case (state_q)
          S_CNT_LO: cnt_lo_q <= in_byte;
          S_CNT_HI: rem_q    <= count_w;
          S_W_LO:   lo_q     <= in_byte;
          S_W_HI: if (!w_bad) begin
            wr_en   <= 1'b1;
            wr_addr <= idx_q;
            wr_data <= W'({in_byte[0], lo_q});
            idx_q   <= idx_q + 1'b1;
            rem_q   <= rem_q - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
